// File: rtl/meas_pkg.sv
// Shared definitions for the ring-oscillator measurement slice:
// common size defaults and the challenge-loader state encoding.
package meas_pkg;

    localparam int unsigned C_IOSCNUM      = 10;
    localparam int unsigned C_MEMDATAWIDTH = 8;
    localparam int unsigned C_MEMADDRWIDTH = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STRB_LO,
        ST_STRB_HI,
        ST_FIN
    } ld_state_t;

endpackage

// File: rtl/chal_pair_check.sv
// Combinational validation of one challenge word: index range and
// degenerate-pair (odd word equal to its even partner) detection.
module chal_pair_check #(
    parameter int unsigned C_IOSCNUM      = meas_pkg::C_IOSCNUM,
    parameter int unsigned C_MEMDATAWIDTH = meas_pkg::C_MEMDATAWIDTH
) (
    input  logic [C_MEMDATAWIDTH-1:0] word_i,
    input  logic [C_MEMDATAWIDTH-1:0] prev_even_i,
    input  logic                      addr_lsb_i,
    output logic                      err_o
);
    import meas_pkg::*;

    logic range_err;
    logic pair_err;

    always_comb begin
        range_err = (32'(word_i) >= C_IOSCNUM);
        pair_err  = addr_lsb_i && (word_i == prev_even_i);
        err_o     = range_err || pair_err;
    end

endmodule

// File: rtl/chal_loader.sv
// Writer side of the challenge memory: validates oscillator-index pairs from a
// valid/ready stream and strobes them into consecutive addresses from 0.
module chal_loader #(
    parameter int unsigned C_IOSCNUM      = meas_pkg::C_IOSCNUM,
    parameter int unsigned C_MEMDATAWIDTH = meas_pkg::C_MEMDATAWIDTH,
    parameter int unsigned C_MEMADDRWIDTH = meas_pkg::C_MEMADDRWIDTH
) (
    input  logic                      I_osc_rst,
    input  logic                      I_clk,
    input  logic                      I_start,
    input  logic [C_MEMADDRWIDTH:0]   I_len,
    input  logic                      I_wr_valid,
    input  logic [C_MEMDATAWIDTH-1:0] I_wr_data,
    output logic                      O_wr_ready,
    output logic [C_MEMADDRWIDTH-1:0] O_mem_addr,
    output logic [C_MEMDATAWIDTH-1:0] O_mem_data,
    output logic                      O_wrclk,
    output logic                      O_ext_mem,
    output logic                      O_busy,
    output logic                      O_done,
    output logic                      O_err
);
    import meas_pkg::*;

    localparam logic [C_MEMADDRWIDTH:0]   C_MAXLEN   = {1'b1, {C_MEMADDRWIDTH{1'b0}}};
    localparam logic [C_MEMADDRWIDTH:0]   C_LEN_ONE  = {{C_MEMADDRWIDTH{1'b0}}, 1'b1};
    localparam logic [C_MEMADDRWIDTH-1:0] C_ADDR_ONE = {{(C_MEMADDRWIDTH-1){1'b0}}, 1'b1};

    ld_state_t                 state_q;
    logic [C_MEMADDRWIDTH-1:0] addr_q;
    logic [C_MEMDATAWIDTH-1:0] data_q;
    logic [C_MEMDATAWIDTH-1:0] prev_q;
    logic [C_MEMADDRWIDTH:0]   len_q;
    logic                      wrclk_q;
    logic                      ext_q;
    logic                      ready_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      err_q;

    logic word_err;
    logic last_word;

    chal_pair_check #(
        .C_IOSCNUM      (C_IOSCNUM),
        .C_MEMDATAWIDTH (C_MEMDATAWIDTH)
    ) u_pair_check (
        .word_i      (I_wr_data),
        .prev_even_i (prev_q),
        .addr_lsb_i  (addr_q[0]),
        .err_o       (word_err)
    );

    // The length check at start guarantees len_q >= 2 here, so no underflow.
    assign last_word = ({1'b0, addr_q} == (len_q - C_LEN_ONE));

    always_ff @(posedge I_clk or posedge I_osc_rst) begin
        if (I_osc_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            prev_q  <= '0;
            len_q   <= '0;
            wrclk_q <= 1'b1;
            ext_q   <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (I_start) begin
                        err_q <= 1'b0;
                        len_q <= I_len;
                        if (I_len == '0) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                            ext_q   <= 1'b0;
                            busy_q  <= 1'b0;
                        end else if (I_len[0] || (I_len > C_MAXLEN)) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                            addr_q  <= '0;
                            ext_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (I_wr_valid && ready_q) begin
                        ready_q <= 1'b0;
                        if (word_err) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            data_q  <= I_wr_data;
                            if (!addr_q[0]) begin
                                prev_q <= I_wr_data;
                            end
                            wrclk_q <= 1'b0;
                            state_q <= ST_STRB_LO;
                        end
                    end
                end
                ST_STRB_LO: begin
                    // Rising edge of the write clock lands while address/data are held.
                    wrclk_q <= 1'b1;
                    state_q <= ST_STRB_HI;
                end
                ST_STRB_HI: begin
                    if (last_word) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                        ext_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        addr_q  <= addr_q + C_ADDR_ONE;
                        ready_q <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign O_wr_ready = ready_q;
    assign O_mem_addr = addr_q;
    assign O_mem_data = data_q;
    assign O_wrclk    = wrclk_q;
    assign O_ext_mem  = ext_q;
    assign O_busy     = busy_q;
    assign O_done     = done_q;
    assign O_err      = err_q;

endmodule

// File: tb/tb_chal_loader.sv
// Self-checking bench for chal_loader: table of short loads plus hand-written
// long, handshake-gapped, boundary-length and mid-load reset sequences.
module tb_chal_loader;

    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int NOSC = 10;
    localparam int NV   = 12;

    logic          I_osc_rst;
    logic          I_clk;
    logic          I_start;
    logic [AW:0]   I_len;
    logic          I_wr_valid;
    logic [DW-1:0] I_wr_data;
    logic          O_wr_ready;
    logic [AW-1:0] O_mem_addr;
    logic [DW-1:0] O_mem_data;
    logic          O_wrclk;
    logic          O_ext_mem;
    logic          O_busy;
    logic          O_done;
    logic          O_err;

    chal_loader #(
        .C_IOSCNUM      (NOSC),
        .C_MEMDATAWIDTH (DW),
        .C_MEMADDRWIDTH (AW)
    ) dut (
        .I_osc_rst  (I_osc_rst),
        .I_clk      (I_clk),
        .I_start    (I_start),
        .I_len      (I_len),
        .I_wr_valid (I_wr_valid),
        .I_wr_data  (I_wr_data),
        .O_wr_ready (O_wr_ready),
        .O_mem_addr (O_mem_addr),
        .O_mem_data (O_mem_data),
        .O_wrclk    (O_wrclk),
        .O_ext_mem  (O_ext_mem),
        .O_busy     (O_busy),
        .O_done     (O_done),
        .O_err      (O_err)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int start_cyc = 0;
    int done_cyc  = 0;
    int done_cnt  = 0;

    logic [AW-1:0] wr_a [$];
    logic [DW-1:0] wr_d [$];
    logic [DW-1:0] mem  [32];
    logic [DW-1:0] wbuf [32];

    typedef struct packed {
        logic [AW:0]        len;
        logic [3:0]         n;
        logic [7:0][DW-1:0] w;
        logic               exp_err;
        logic [1:0]         exp_done;
        logic [3:0]         exp_wr;
        logic               chk_ext;
        logic               exp_ext;
    } vec_t;

    vec_t vt [NV];

    always @(posedge I_clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge I_clk) begin
        if (O_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc_cnt;
        end
    end

    // Behavioural memory: captures on the rising edge of the write clock.
    always @(posedge O_wrclk) begin
        if (I_osc_rst === 1'b0) begin
            wr_a.push_back(O_mem_addr);
            wr_d.push_back(O_mem_data);
            mem[O_mem_addr] = O_mem_data;
        end
    end

    function automatic logic [7:0][DW-1:0] pk(input logic [DW-1:0] a, b, c, d, e, f, g, h);
        return {h, g, f, e, d, c, b, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic begin_load(input logic [AW:0] len);
        wr_a.delete();
        wr_d.delete();
        done_cnt   = 0;
        I_len      = len;
        I_start    = 1'b1;
        I_wr_valid = 1'b1;
        I_wr_data  = wbuf[0];
        @(negedge I_clk);
        I_start    = 1'b0;
        I_wr_valid = 1'b0;
        start_cyc  = cyc_cnt;
    endtask

    task automatic feed(input int n, input bit tog);
        int i = 0;
        int cyc = 0;
        bit ph = 1'b1;
        bit acc;
        while (i < n && cyc < 300 && O_err !== 1'b1) begin
            I_wr_valid = tog ? ph : 1'b1;
            ph = ~ph;
            I_wr_data = wbuf[i];
            acc = (O_wr_ready === 1'b1) && I_wr_valid;
            @(negedge I_clk);
            cyc++;
            if (acc) i++;
        end
        I_wr_valid = 1'b0;
        check("feed_bound", 32'(cyc < 300), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_addr"},  32'(O_mem_addr), 32'd0);
        check({tag, "_data"},  32'(O_mem_data), 32'd0);
        check({tag, "_wrclk"}, 32'(O_wrclk),    32'd1);
        check({tag, "_ext"},   32'(O_ext_mem),  32'd1);
        check({tag, "_ready"}, 32'(O_wr_ready), 32'd0);
        check({tag, "_busy"},  32'(O_busy),     32'd0);
        check({tag, "_done"},  32'(O_done),     32'd0);
        check({tag, "_err"},   32'(O_err),      32'd0);
    endtask

    initial begin
        //            len    n      words                         err   done  wr     chk   ext
        vt[0]  = '{7'd4,  4'd4, pk(0, 1, 2, 12, 0, 0, 0, 0),    1'b1, 2'd0, 4'd3, 1'b1, 1'b1};
        vt[1]  = '{7'd4,  4'd4, pk(3, 4, 5, 5, 0, 0, 0, 0),     1'b1, 2'd0, 4'd3, 1'b1, 1'b1};
        vt[2]  = '{7'd7,  4'd0, pk(0, 0, 0, 0, 0, 0, 0, 0),     1'b1, 2'd0, 4'd0, 1'b1, 1'b1};
        vt[3]  = '{7'd0,  4'd0, pk(0, 0, 0, 0, 0, 0, 0, 0),     1'b0, 2'd1, 4'd0, 1'b1, 1'b0};
        vt[4]  = '{7'd33, 4'd0, pk(0, 0, 0, 0, 0, 0, 0, 0),     1'b1, 2'd0, 4'd0, 1'b0, 1'b0};
        vt[5]  = '{7'd2,  4'd2, pk(6, 7, 0, 0, 0, 0, 0, 0),     1'b0, 2'd1, 4'd2, 1'b1, 1'b0};
        vt[6]  = '{7'd2,  4'd2, pk(9, 10, 0, 0, 0, 0, 0, 0),    1'b1, 2'd0, 4'd1, 1'b1, 1'b1};
        vt[7]  = '{7'd2,  4'd2, pk(9, 9, 0, 0, 0, 0, 0, 0),     1'b1, 2'd0, 4'd1, 1'b1, 1'b1};
        vt[8]  = '{7'd4,  4'd4, pk(4, 5, 5, 4, 0, 0, 0, 0),     1'b0, 2'd1, 4'd4, 1'b1, 1'b0};
        vt[9]  = '{7'd4,  4'd4, pk(1, 2, 2, 2, 0, 0, 0, 0),     1'b1, 2'd0, 4'd3, 1'b1, 1'b1};
        vt[10] = '{7'd6,  4'd6, pk(0, 9, 9, 0, 3, 8, 0, 0),     1'b0, 2'd1, 4'd6, 1'b1, 1'b0};
        vt[11] = '{7'd8,  4'd8, pk(255, 1, 2, 3, 4, 5, 6, 7),   1'b1, 2'd0, 4'd0, 1'b1, 1'b1};

        I_osc_rst  = 1'b1;
        I_start    = 1'b0;
        I_len      = '0;
        I_wr_valid = 1'b0;
        I_wr_data  = '0;
        for (int j = 0; j < 32; j++) begin
            wbuf[j] = '0;
            mem[j]  = '1;
        end
        repeat (2) @(negedge I_clk);
        check_reset_vals("rst");
        I_osc_rst = 1'b0;
        @(negedge I_clk);

        // Table-driven short loads
        for (int k = 0; k < NV; k++) begin
            for (int j = 0; j < 8; j++) wbuf[j] = vt[k].w[j];
            begin_load(vt[k].len);
            feed(int'(vt[k].n), 1'b0);
            repeat (6) @(negedge I_clk);
            check($sformatf("v%0d_err", k),   32'(O_err),      32'(vt[k].exp_err));
            check($sformatf("v%0d_done", k),  32'(done_cnt),   32'(vt[k].exp_done));
            check($sformatf("v%0d_nwr", k),   32'(wr_a.size()), 32'(vt[k].exp_wr));
            check($sformatf("v%0d_busy", k),  32'(O_busy),     32'd0);
            check($sformatf("v%0d_ready", k), 32'(O_wr_ready), 32'd0);
            if (vt[k].chk_ext) check($sformatf("v%0d_ext", k), 32'(O_ext_mem), 32'(vt[k].exp_ext));
            for (int j = 0; j < wr_a.size() && j < 8; j++) begin
                check($sformatf("v%0d_waddr%0d", k, j), 32'(wr_a[j]), 32'(j));
                check($sformatf("v%0d_wdata%0d", k, j), 32'(wr_d[j]), 32'(vt[k].w[j]));
            end
        end

        // Ten words, valid held high: 3 cycles per word, done 30 cycles after start
        for (int j = 0; j < 32; j++) mem[j] = '1;
        for (int j = 0; j < 10; j++) wbuf[j] = DW'(j);
        begin_load(7'd10);
        feed(10, 1'b0);
        repeat (6) @(negedge I_clk);
        check("l10_done", 32'(done_cnt), 32'd1);
        check("l10_lat", 32'(done_cyc - start_cyc), 32'd30);
        check("l10_nwr", 32'(wr_a.size()), 32'd10);
        check("l10_ext", 32'(O_ext_mem), 32'd0);
        check("l10_err", 32'(O_err), 32'd0);
        for (int j = 0; j < 10; j++) check($sformatf("l10_mem%0d", j), 32'(mem[j]), 32'(j));

        // Same load with valid toggling: contents identical
        for (int j = 0; j < 32; j++) mem[j] = '1;
        begin_load(7'd10);
        feed(10, 1'b1);
        repeat (6) @(negedge I_clk);
        check("tog_done", 32'(done_cnt), 32'd1);
        check("tog_nwr", 32'(wr_a.size()), 32'd10);
        check("tog_err", 32'(O_err), 32'd0);
        for (int j = 0; j < 10; j++) check($sformatf("tog_mem%0d", j), 32'(mem[j]), 32'(j));

        // Full-capacity load
        for (int j = 0; j < 32; j++) begin
            mem[j]  = '1;
            wbuf[j] = DW'(j % 10);
        end
        begin_load(7'd32);
        feed(32, 1'b0);
        repeat (6) @(negedge I_clk);
        check("l32_done", 32'(done_cnt), 32'd1);
        check("l32_nwr", 32'(wr_a.size()), 32'd32);
        if (wr_a.size() == 32) check("l32_last_addr", 32'(wr_a[31]), 32'd31);
        for (int j = 0; j < 32; j++) check($sformatf("l32_mem%0d", j), 32'(mem[j]), 32'(j % 10));

        // Zero length: done visible in the cycle right after the start edge
        begin_load(7'd0);
        check("l0_done_now", 32'(O_done), 32'd1);
        check("l0_ext_now", 32'(O_ext_mem), 32'd0);
        check("l0_busy_now", 32'(O_busy), 32'd0);
        repeat (3) @(negedge I_clk);
        check("l0_done_after", 32'(O_done), 32'd0);
        check("l0_done_cnt", 32'(done_cnt), 32'd1);

        // Reset while word 2 is in its low strobe phase
        for (int j = 0; j < 10; j++) wbuf[j] = DW'(j);
        begin_load(7'd10);
        feed(3, 1'b0);
        check("rstmid_strb_lo", 32'(O_wrclk), 32'd0);
        I_osc_rst = 1'b1;
        #1;
        check_reset_vals("rstmid");
        @(negedge I_clk);
        I_osc_rst = 1'b0;
        @(negedge I_clk);
        wbuf[0] = 8'd7;
        wbuf[1] = 8'd8;
        begin_load(7'd2);
        feed(2, 1'b0);
        repeat (6) @(negedge I_clk);
        check("after_rst_nwr", 32'(wr_a.size()), 32'd2);
        if (wr_a.size() == 2) begin
            check("after_rst_a0", 32'(wr_a[0]), 32'd0);
            check("after_rst_a1", 32'(wr_a[1]), 32'd1);
            check("after_rst_d0", 32'(wr_d[0]), 32'd7);
            check("after_rst_d1", 32'(wr_d[1]), 32'd8);
        end
        check("after_rst_done", 32'(done_cnt), 32'd1);
        check("after_rst_err", 32'(O_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chal_loader.md
Name: chal_loader

Overview:
- Writer side of the challenge memory that the oscillator measurement block reads.
- Accepts a stream of oscillator-index words over a valid/ready handshake, validates them as challenge pairs and writes them to consecutive memory addresses from 0.
- Write strobe: data held steady, then write clock driven low, then high; memory captures on the rising edge.
- Owns the memory address mux (O_ext_mem) while loading, then hands the bus to the measurement block.

Parameters:
- C_IOSCNUM, 10, number of ring oscillators; valid index range is 0..C_IOSCNUM-1.
- C_MEMDATAWIDTH, 8, memory word width.
- C_MEMADDRWIDTH, 5, memory address width; capacity is 2^C_MEMADDRWIDTH words.

Ports:
- I_osc_rst  in  1  reset; asynchronous, active-high.
- I_clk  in  1  system clock; all logic is on the rising edge.
- I_start  in  1  load request, sampled only in IDLE.
- I_len  in  C_MEMADDRWIDTH+1  number of words to load; must be even.
- I_wr_valid  in  1  input word valid.
- I_wr_data  in  C_MEMDATAWIDTH  oscillator index word.
- O_wr_ready  out  1  block accepts a word this cycle.
- O_mem_addr  out  C_MEMADDRWIDTH  memory write address.
- O_mem_data  out  C_MEMDATAWIDTH  memory write data.
- O_wrclk  out  1  memory write clock; memory writes on its rising edge.
- O_ext_mem  out  1  1 = loader owns the memory address bus; 0 = measurement block owns it.
- O_busy  out  1  load in progress.
- O_done  out  1  one-cycle pulse when a load completes successfully.
- O_err  out  1  sticky error flag; cleared by the next accepted I_start.

Behaviour:
- Reset values (asynchronous, while I_osc_rst=1):
  - state IDLE, O_mem_addr=0, O_mem_data=0
  - O_wrclk=1, O_ext_mem=1
  - O_wr_ready=0, O_busy=0, O_done=0, O_err=0
- States: IDLE, WAIT, STRB_LO, STRB_HI, FIN.
- IDLE:
  - O_wr_ready=0.
  - On I_start=1, O_err clears, then:
    - I_len=0 -> FIN.
    - I_len odd, or I_len > 2^C_MEMADDRWIDTH -> O_err=1, stay IDLE, no writes.
    - Otherwise -> WAIT with O_mem_addr=0, O_ext_mem=1, O_busy=1.
- WAIT:
  - O_wr_ready=1.
  - On I_wr_valid & O_wr_ready, check the word:
    - I_wr_data >= C_IOSCNUM -> error.
    - Odd address and I_wr_data equal to the word accepted at the preceding even address -> error (degenerate pair).
  - Error: O_err=1, O_busy=0, go to IDLE, nothing written, O_ext_mem stays 1.
  - Otherwise: O_mem_data <= I_wr_data, go to STRB_LO.
  - A previously latched even-address word is held internally for the pair check.
- STRB_LO: O_wrclk=0, O_wr_ready=0, go to STRB_HI.
- STRB_HI:
  - O_wrclk=1; this rising edge is the memory write.
  - If O_mem_addr == I_len-1 (I_len latched at start) -> FIN.
  - Otherwise O_mem_addr+1 -> WAIT.
- Per-word cost: 3 cycles minimum (accept, low, high). O_mem_addr and O_mem_data are stable for the full low/high phase.
- FIN: O_ext_mem=0, O_done=1 for exactly one cycle, O_busy=0, go to IDLE.
- O_ext_mem stays 0 until the next accepted I_start.
- O_mem_addr never wraps; the length check guarantees the last address is at most 2^C_MEMADDRWIDTH-1.
- I_start while not IDLE is ignored. I_wr_valid outside WAIT is ignored; no word is lost because O_wr_ready=0.
- A word presented with I_start in the same cycle is not accepted; acceptance begins the cycle after.
- Reset mid-load: outputs return to reset values immediately.
  - Reset during STRB_LO produces a rising edge on O_wrclk; memory content is undefined after any interrupted load. This is accepted behaviour.
  - The next load restarts at address 0.

Decomposition:
- meas_pkg holds:
  - state encoding localparams (IDLE, WAIT, STRB_LO, STRB_HI, FIN)
  - shared defaults C_IOSCNUM, C_MEMDATAWIDTH, C_MEMADDRWIDTH, common with the measurement block and the memory
- One sub-module, chal_pair_check: combinational index-range and pair-equality check. Inputs: word, previous even word, address LSB. Output: error.

Test Plan:
- Load I_len=10, words 0..9, I_wr_valid held 1 -> 10 rising edges of O_wrclk at addresses 0..9; memory reads back 0..9; O_done pulses once ~30 cycles after start; O_ext_mem falls to 0; O_err=0.
- Same load with I_wr_valid toggling every other WAIT cycle -> identical memory contents; no O_wrclk edge while I_wr_valid=0; O_wr_ready=1 only in WAIT.
- Words 0,1,2,12 with I_len=4 -> writes at addresses 0..2 only; O_err=1 the cycle after the 12 is offered; O_ext_mem stays 1; O_done never pulses.
- Words 3,4,5,5 with I_len=4 -> addresses 0..2 written; pair (5,5) rejected; O_err=1; address 3 unchanged.
- I_len=7 -> O_err=1, no write edges. I_len=0 -> O_done pulse one cycle later, O_ext_mem=0, no writes. I_len=33 -> O_err=1. I_len=32 -> last write at address 31, then O_done.
- Assert I_osc_rst during STRB_LO of word 2 -> all outputs at reset values immediately. A new start with I_len=2 writes addresses 0 and 1 and completes with O_done.
